uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_bit_timer.sv | 33 +++
 rtl/uart_tx.sv | 128 ++++++++++++
 tb/tb_uart_tx.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state codes, parity encodings and helpers
// Shared by uart_tx and uart_rx.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_SEND_BYTE = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Clocks per bit, integer-truncated; CLK_FRE is given in MHz.
  function automatic int cycle_calc(input int clk_fre, input int baud_rate);
    return (clk_fre * 1000000) / baud_rate;
  endfunction

  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    return (mode == PAR_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - restartable bit-period counter
// Pulses bit_done for one clock when the count reaches CYCLE-1, then wraps to 0.
module uart_bit_timer #(
  parameter int CYCLE = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic bit_done
);

  localparam logic [15:0] LAST = 16'(CYCLE - 1);

  logic [15:0] cycle_cnt_q, cycle_cnt_d;

  assign bit_done = !restart && (cycle_cnt_q == LAST);

  always_comb begin
    cycle_cnt_d = cycle_cnt_q + 16'd1;
    if (restart || cycle_cnt_q == LAST) begin
      cycle_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter, 8 data bits, optional parity, 1 or 2 stop bits
// One byte per valid/ready handshake; tx_pin and tx_data_ready are registered.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FRE   = 50,
  parameter int BAUD_RATE = 115200,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_data_valid,
  output logic       tx_data_ready,
  output logic       tx_pin
);

  localparam int CYCLE = cycle_calc(CLK_FRE, BAUD_RATE);

  uart_state_e state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  tx_bits_q, tx_bits_d;
  logic        par_q, par_d;
  logic        tx_pin_q, tx_pin_d;
  logic        ready_q, ready_d;
  logic        bit_done;

  // Holding the timer in restart while idle aligns bit boundaries to the accept edge.
  uart_bit_timer #(.CYCLE(CYCLE)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (state_q == S_IDLE),
    .bit_done (bit_done)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    tx_bits_d = tx_bits_q;
    par_d     = par_q;
    tx_pin_d  = tx_pin_q;
    ready_d   = ready_q;
    unique case (state_q)
      S_IDLE: begin
        ready_d  = 1'b1;
        tx_pin_d = 1'b1;
        if (tx_data_valid && ready_q) begin
          tx_bits_d = tx_data;
          par_d     = parity_bit(tx_data, PARITY);
          tx_pin_d  = 1'b0;
          ready_d   = 1'b0;
          bit_cnt_d = '0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (bit_done) begin
          tx_pin_d = tx_bits_q[0];
          state_d  = S_SEND_BYTE;
        end
      end
      S_SEND_BYTE: begin
        // The latched byte shifts right so the next bit is always at index 1.
        if (bit_done) begin
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = '0;
            if (PARITY != PAR_NONE) begin
              tx_pin_d = par_q;
              state_d  = S_PARITY;
            end else begin
              tx_pin_d = 1'b1;
              state_d  = S_STOP;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_bits_d = {1'b0, tx_bits_q[7:1]};
            tx_pin_d  = tx_bits_q[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_done) begin
          tx_pin_d = 1'b1;
          state_d  = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_done) begin
          if (bit_cnt_q == 3'(STOP_BITS - 1)) begin
            bit_cnt_d = '0;
            ready_d   = 1'b1;
            state_d   = S_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      default: begin
        tx_pin_d = 1'b1;
        ready_d  = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      tx_bits_q <= '0;
      par_q     <= 1'b0;
      tx_pin_q  <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      tx_bits_q <= tx_bits_d;
      par_q     <= par_d;
      tx_pin_q  <= tx_pin_d;
      ready_q   <= ready_d;
    end
  end

  assign tx_pin        = tx_pin_q;
  assign tx_data_ready = ready_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx
// Four instances: defaults, even parity with 2 stops, odd parity, and a fast even/2-stop copy.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [7:0]     data_a [N];
  logic [N-1:0]   valid_v = '0;
  wire  [N-1:0]   ready_v;
  wire  [N-1:0]   pin_v;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    logic       exp_odd;
    logic       exp_even;
  } vec_t;

  vec_t tbl [4];

  always #5 clk = ~clk;

  uart_tx u_def (
    .clk(clk), .rst_n(rst_n), .tx_data(data_a[0]), .tx_data_valid(valid_v[0]),
    .tx_data_ready(ready_v[0]), .tx_pin(pin_v[0]));
  uart_tx #(.PARITY(2), .STOP_BITS(2)) u_e2 (
    .clk(clk), .rst_n(rst_n), .tx_data(data_a[1]), .tx_data_valid(valid_v[1]),
    .tx_data_ready(ready_v[1]), .tx_pin(pin_v[1]));
  uart_tx #(.PARITY(1), .STOP_BITS(1)) u_o1 (
    .clk(clk), .rst_n(rst_n), .tx_data(data_a[2]), .tx_data_valid(valid_v[2]),
    .tx_data_ready(ready_v[2]), .tx_pin(pin_v[2]));
  uart_tx #(.CLK_FRE(1), .BAUD_RATE(100000), .PARITY(2), .STOP_BITS(2)) u_fast (
    .clk(clk), .rst_n(rst_n), .tx_data(data_a[3]), .tx_data_valid(valid_v[3]),
    .tx_data_ready(ready_v[3]), .tx_pin(pin_v[3]));

  function automatic int cyc_of(input int id);
    return (id == 3) ? 10 : 434;
  endfunction

  function automatic int par_of(input int id);
    case (id)
      1, 3:    return PAR_EVEN;
      2:       return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

  function automatic int stp_of(input int id);
    return (id == 1 || id == 3) ? 2 : 1;
  endfunction

  function automatic int frame_len(input int id);
    return (9 + ((par_of(id) != PAR_NONE) ? 1 : 0) + stp_of(id)) * cyc_of(id);
  endfunction

  // Parity bit chosen so the total count of ones is odd (odd) or even (even).
  function automatic logic model_par(input int id, input logic [7:0] d);
    int ones;
    ones = $countones(d);
    if (par_of(id) == PAR_ODD) return (ones % 2 == 0);
    return (ones % 2 == 1);
  endfunction

  // Expected line level in clock i after the accept edge.
  function automatic logic model_bit(input int id, input logic [7:0] d, input int i);
    int b;
    b = i / cyc_of(id);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (par_of(id) != PAR_NONE && b == 9) return model_par(id, d);
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Waits for ready, hands over one byte and follows the whole frame; ends on the
  // negedge after ready re-rises, with valid still high when hold is set.
  task automatic send_frame(input int id, input logic [7:0] d, input bit hold, input bit mess,
                            output logic [7:0] dec, output logic dec_par, output int waited);
    int c, len, wave_err, first_ready, b;
    c = cyc_of(id);
    len = frame_len(id);
    waited = 0;
    while (ready_v[id] !== 1'b1 && waited < 20 * c + 100) begin
      @(negedge clk);
      waited++;
    end
    check($sformatf("ready_wait_%0d", id), 32'(ready_v[id]), 32'd1);
    data_a[id] = d;
    valid_v[id] = 1'b1;
    @(posedge clk);
    wave_err = 0;
    first_ready = -1;
    dec = '0;
    dec_par = 1'b0;
    for (int i = 0; i <= len; i++) begin
      @(negedge clk);
      if (i == 0 && !hold) valid_v[id] = 1'b0;
      if (mess && i == len / 3) begin
        data_a[id] = 8'hFF;
        valid_v[id] = 1'b1;
      end
      if (mess && i == len / 3 + c) valid_v[id] = 1'b0;
      if (i < len) begin
        if (pin_v[id] !== model_bit(id, d, i)) wave_err++;
      end else if (pin_v[id] !== 1'b1) begin
        wave_err++;
      end
      if (ready_v[id] === 1'b1 && first_ready < 0) first_ready = i;
      if (i % c == c / 2) begin
        b = i / c;
        if (b >= 1 && b <= 8) dec[b-1] = pin_v[id];
        if (b == 9) dec_par = pin_v[id];
      end
    end
    check($sformatf("wave_%0d_%02h", id, d), 32'(wave_err), 32'd0);
    check($sformatf("frame_len_%0d", id), 32'(first_ready), 32'(len));
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] dec;
    logic       dp;
    int         w, err_a, err_b;
    bit         prev_hold;

    tbl[0] = '{8'h07, 1'b0, 1'b1};
    tbl[1] = '{8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'hFF, 1'b1, 1'b0};
    tbl[3] = '{8'h80, 1'b0, 1'b1};
    for (int k = 0; k < N; k++) data_a[k] = 8'h00;

    // Reset and idle
    err_a = 0;
    err_b = 0;
    repeat (5) begin
      @(negedge clk);
      if (pin_v !== 4'hF) err_a++;
      if (ready_v !== 4'h0) err_b++;
    end
    check("reset_pin_high", 32'(err_a), 32'd0);
    check("reset_ready_low", 32'(err_b), 32'd0);
    rst_n = 1'b1;
    #1;
    check("ready_before_first_edge", 32'(ready_v), 32'h0);
    @(negedge clk);
    check("ready_first_edge", 32'(ready_v), 32'hF);
    err_a = 0;
    repeat (30) begin
      @(negedge clk);
      if (pin_v !== 4'hF || ready_v !== 4'hF) err_a++;
    end
    check("idle_no_start", 32'(err_a), 32'd0);

    // Single byte at defaults
    send_frame(0, 8'h55, 1'b0, 1'b0, dec, dp, w);
    check("dec_55", 32'(dec), 32'h55);

    // Back-to-back with valid held
    send_frame(0, 8'hA3, 1'b1, 1'b0, dec, dp, w);
    check("dec_A3", 32'(dec), 32'hA3);
    send_frame(0, 8'h0F, 1'b0, 1'b0, dec, dp, w);
    check("b2b_gap", 32'(w), 32'd0);
    check("dec_0F", 32'(dec), 32'h0F);

    // Inputs ignored while busy
    send_frame(0, 8'h12, 1'b0, 1'b1, dec, dp, w);
    check("dec_12_ignored", 32'(dec), 32'h12);
    err_a = 0;
    repeat (3 * 434) begin
      @(negedge clk);
      if (pin_v[0] !== 1'b1 || ready_v[0] !== 1'b1) err_a++;
    end
    check("no_second_frame", 32'(err_a), 32'd0);

    // Reset during data bit 3 of 0xC6
    data_a[0] = 8'hC6;
    valid_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_v[0] = 1'b0;
    repeat (4 * 434 + 100) @(negedge clk);
    check("abort_bit3_level", 32'(pin_v[0]), 32'd0);
    rst_n = 1'b0;
    #1;
    check("abort_pin_async", 32'(pin_v[0]), 32'd1);
    check("abort_ready", 32'(ready_v[0]), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send_frame(0, 8'h3C, 1'b0, 1'b0, dec, dp, w);
    check("dec_3C_after_abort", 32'(dec), 32'h3C);

    // Parity/stop table on the two parity instances in parallel
    fork
      begin
        logic [7:0] d1;
        logic       p1;
        int         w1;
        for (int k = 0; k < 4; k++) begin
          send_frame(1, tbl[k].data, 1'b0, 1'b0, d1, p1, w1);
          check($sformatf("tbl_even_byte_%0d", k), 32'(d1), 32'(tbl[k].data));
          check($sformatf("tbl_even_par_%0d", k), 32'(p1), 32'(tbl[k].exp_even));
        end
      end
      begin
        logic [7:0] d2;
        logic       p2;
        int         w2;
        for (int k = 0; k < 4; k++) begin
          send_frame(2, tbl[k].data, 1'b0, 1'b0, d2, p2, w2);
          check($sformatf("tbl_odd_byte_%0d", k), 32'(d2), 32'(tbl[k].data));
          check($sformatf("tbl_odd_par_%0d", k), 32'(p2), 32'(tbl[k].exp_odd));
        end
      end
    join

    // Random bytes, gaps and back-to-back runs on the fast instance
    prev_hold = 1'b0;
    for (int k = 0; k < 40; k++) begin
      logic [7:0] rd;
      bit         hold;
      rd = 8'($urandom);
      hold = ($urandom_range(0, 1) == 1);
      send_frame(3, rd, hold, 1'b0, dec, dp, w);
      check($sformatf("rnd_byte_%0d", k), 32'(dec), 32'(rd));
      check($sformatf("rnd_par_%0d", k), 32'(dp), 32'(model_par(3, rd)));
      if (prev_hold) check($sformatf("rnd_b2b_gap_%0d", k), 32'(w), 32'd0);
      prev_hold = hold;
      if (!hold) repeat ($urandom_range(0, 15)) @(negedge clk);
    end
    valid_v[3] = 1'b0;
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
